// File: rtl/store_part_word_rmw_if.sv
// Pipeline M-stage store request plus data-memory port B, as seen by the store formatter.
interface store_part_word_rmw_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  MemWriteM;
  logic [2:0]            StoreSrcM;
  logic [ADDR_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [DATA_WIDTH-1:0] MemRdDataB;
  logic [ADDR_WIDTH-3:0] MemAddrB;
  logic                  MemRdEnB;
  logic                  MemWrEnB;
  logic [DATA_WIDTH-1:0] MemWrDataB;
  logic                  StallM;
  logic                  MisalignedM;

  modport slave (
    input  MemWriteM, StoreSrcM, ALUResultM, WriteDataM, MemRdDataB,
    output MemAddrB, MemRdEnB, MemWrEnB, MemWrDataB, StallM, MisalignedM
  );

  modport master (
    output MemWriteM, StoreSrcM, ALUResultM, WriteDataM, MemRdDataB,
    input  MemAddrB, MemRdEnB, MemWrEnB, MemWrDataB, StallM, MisalignedM
  );
endinterface

// File: rtl/store_part_word_rmw.sv
// Store formatter for a word-only memory port: SW writes directly, SB/SH read-merge-write
// with a single pipeline stall cycle.
//   state | meaning
//   IDLE  | accept a store from M; SW writes now, SB/SH issue the read
//   MERGE | read data is back; write the merged word, release the stall
module store_part_word_rmw #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  store_part_word_rmw_if.slave bus
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [1:0]            off_q;
  logic                  half_q;
  logic [15:0]           data_q;

  logic                  is_sb, is_sh, is_sw, legal, load_rmw;
  logic                  rd_en, wr_en, stall, misaligned;
  logic [ADDR_WIDTH-3:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata, merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      off_q  <= '0;
      half_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_next;
      if (load_rmw) begin
        addr_q <= bus.ALUResultM[ADDR_WIDTH-1:2];
        off_q  <= bus.ALUResultM[1:0];
        half_q <= is_sh;
        data_q <= bus.WriteDataM[15:0];
      end
    end
  end

  always_comb begin
    is_sb = (bus.StoreSrcM == 3'b000);
    is_sh = (bus.StoreSrcM == 3'b001);
    is_sw = (bus.StoreSrcM == 3'b010);
    legal = is_sb
          | (is_sh & ~bus.ALUResultM[0])
          | (is_sw & (bus.ALUResultM[1:0] == 2'b00));
  end

  always_comb begin
    state_next = state;
    load_rmw   = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;
    addr_o     = '0;
    wdata      = '0;
    merged     = bus.MemRdDataB;

    // Lanes not selected by the latched offset keep the word just read back.
    if (half_q) begin
      if (off_q[1]) merged[31:16] = data_q;
      else          merged[15:0]  = data_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end

    case (state)
      IDLE: begin
        if (bus.MemWriteM) begin
          if (!legal) begin
            misaligned = 1'b1;
          end else if (is_sw) begin
            wr_en  = 1'b1;
            addr_o = bus.ALUResultM[ADDR_WIDTH-1:2];
            wdata  = bus.WriteDataM;
          end else begin
            rd_en      = 1'b1;
            stall      = 1'b1;
            addr_o     = bus.ALUResultM[ADDR_WIDTH-1:2];
            load_rmw   = 1'b1;
            state_next = MERGE;
          end
        end
      end
      MERGE: begin
        wr_en      = 1'b1;
        addr_o     = addr_q;
        wdata      = merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst_n kills an in-flight merge write the moment reset asserts.
  assign bus.MemRdEnB    = rst_n & rd_en;
  assign bus.MemWrEnB    = rst_n & wr_en;
  assign bus.StallM      = rst_n & stall;
  assign bus.MisalignedM = rst_n & misaligned;
  assign bus.MemAddrB    = rst_n ? addr_o : '0;
  assign bus.MemWrDataB  = rst_n ? wdata  : '0;

endmodule

// File: tb/tb_store_part_word_rmw.sv
// Directed bench for store_part_word_rmw: word memory model on port B, write scoreboard.
module tb_store_part_word_rmw;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [61:0] exp_q[$];
  logic [31:0] mem [0:255];
  logic [31:0] rd_q;
  logic [31:0] model;

  store_part_word_rmw_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  store_part_word_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.MemRdEnB) rd_q <= mem[bus.MemAddrB[7:0]];
    if (bus.MemWrEnB) mem[bus.MemAddrB[7:0]] <= bus.MemWrDataB;
  end
  assign bus.MemRdDataB = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic sample();
    logic [61:0] e;
    @(negedge clk);
    if (bus.MemWrEnB) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {2'b00, bus.MemAddrB}, {2'b00, e[61:32]});
        chk("wr_data", bus.MemWrDataB, e[31:0]);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] src, input logic [31:0] addr,
                       input logic [31:0] data);
    bus.MemWriteM  = en;
    bus.StoreSrcM  = src;
    bus.ALUResultM = addr;
    bus.WriteDataM = data;
  endtask

  task automatic store_sw(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 3'b010, addr, data);
    exp_q.push_back({addr[31:2], data});
    sample();
    chk("sw_ctl", {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'b0100);
    advance();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic store_rmw(input logic [2:0] src, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_word);
    drive(1'b1, src, addr, data);
    exp_q.push_back({addr[31:2], exp_word});
    sample();
    chk("rmw_rd_ctl", {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'b1010);
    chk("rmw_rd_addr", {2'b00, bus.MemAddrB}, {2'b00, addr[31:2]});
    advance();
    sample();
    chk("rmw_wr_ctl", {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'b0100);
    advance();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic check_bad(input string tag, input logic [2:0] src, input logic [31:0] addr);
    drive(1'b1, src, addr, 32'hFFFF_FFFF);
    sample();
    chk(tag, {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'b0001);
    advance();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 3'($urandom), $urandom, $urandom);
      sample();
      chk("rst_ctl", {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'd0);
      chk("rst_addr", {2'b00, bus.MemAddrB}, 32'd0);
      chk("rst_wdata", bus.MemWrDataB, 32'd0);
      advance();
    end
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    rst_n = 1'b1;
    sample();
    chk("idle_ctl", {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'd0);
    advance();

    store_sw(32'h100, 32'hDEAD_BEEF);
    store_sw(32'h100, 32'h1122_3344);
    store_rmw(3'b000, 32'h102, 32'h0000_00AB, 32'h11AB_3344);

    store_sw(32'h100, 32'h1122_3344);
    store_rmw(3'b001, 32'h102, 32'h0000_CAFE, 32'hCAFE_3344);
    store_sw(32'h100, 32'h1122_3344);
    store_rmw(3'b001, 32'h100, 32'h1234_CAFE, 32'h1122_CAFE);

    check_bad("mis_sh_101", 3'b001, 32'h101);
    check_bad("mis_sw_102", 3'b010, 32'h102);
    check_bad("illegal_011", 3'b011, 32'h100);

    // Reset in MERGE must drop the write.
    store_sw(32'h100, 32'h1122_3344);
    drive(1'b1, 3'b000, 32'h102, 32'h77);
    sample();
    chk("abort_rd", {31'd0, bus.MemRdEnB}, 32'd1);
    advance();
    rst_n = 1'b0;
    sample();
    chk("abort_wr", {31'd0, bus.MemWrEnB}, 32'd0);
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    advance();
    rst_n = 1'b1;
    sample();
    chk("abort_idle", {28'd0, bus.MemRdEnB, bus.MemWrEnB, bus.StallM, bus.MisalignedM}, 32'd0);
    chk("abort_mem", mem[8'h40], 32'h1122_3344);
    advance();

    // Back-to-back SBs to one word: the second read must see the first merge.
    store_rmw(3'b000, 32'h100, 32'h0000_0055, 32'h1122_3355);
    store_rmw(3'b000, 32'h103, 32'h0000_0066, 32'h6622_3355);
    chk("b2b_mem", mem[8'h40], 32'h6622_3355);

    model = 32'hA5A5_5A5A;
    store_sw(32'h200, model);
    for (int lane = 0; lane < 4; lane++) begin
      logic [7:0] d;
      d = 8'($urandom);
      model = (model & ~(32'hFF << (8 * lane))) | ({24'd0, d} << (8 * lane));
      store_rmw(3'b000, 32'h200 + 32'(lane), {24'hFFFFFF, d}, model);
    end
    chk("lane_mem", mem[8'h80], model);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
